// File: rtl/relu_share_sched.sv
// Round-robin scheduler sharing one registered relu between NUM_REQ accumulators.
// One item is in flight at a time: grant -> CALC -> OUT (held until accepted).

module relu #(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*dataWidth-1:0] x,
  output logic [dataWidth-1:0]   out
);

  localparam int XW = 2 * dataWidth;

  logic [dataWidth-1:0] w_y;

  // Clamp negatives to zero, saturate values whose integer part overflows.
  always_comb begin
    w_y = {dataWidth{1'b0}};
    if (x[XW-1]) begin
      w_y = {dataWidth{1'b0}};
    end else if (|x[XW-1 -: weightIntWidth+1]) begin
      w_y = {1'b0, {(dataWidth-1){1'b1}}};
    end else begin
      w_y = x[XW-1-weightIntWidth -: dataWidth];
    end
  end

  // Result register, refreshed every cycle from the held operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= {dataWidth{1'b0}};
    end else begin
      out <= w_y;
    end
  end

endmodule

module relu_share_sched #(
  parameter int NUM_REQ        = 4,
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*2*dataWidth-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic [dataWidth-1:0]           out_data,
  output logic [ID_W-1:0]                out_id,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int OPW = 2 * dataWidth;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [OPW-1:0]    r_operand;
  logic [ID_W-1:0]   r_out_id;
  logic [ID_W-1:0]   r_rr;

  logic              w_grant_ok;
  logic              w_grant;
  logic [ID_W-1:0]   w_win_idx;
  logic [OPW-1:0]    w_win_data;
  logic [NUM_REQ-1:0] w_req_ready;

  assign w_grant_ok = (r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready);

  // Rotating-priority search starting just after the last winner.
  always_comb begin : arb_blk
    logic [ID_W:0]   v_sum;
    logic [ID_W-1:0] v_idx;
    logic            v_hit;
    v_sum     = {(ID_W+1){1'b0}};
    v_idx     = {ID_W{1'b0}};
    v_hit     = 1'b0;
    w_grant   = 1'b0;
    w_win_idx = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_sum     = {1'b0, r_rr} + (ID_W+1)'(k);
      v_sum     = (v_sum >= (ID_W+1)'(NUM_REQ)) ? (v_sum - (ID_W+1)'(NUM_REQ)) : v_sum;
      v_idx     = v_sum[ID_W-1:0];
      v_hit     = w_grant_ok & req_valid[v_idx] & ~w_grant;
      w_win_idx = v_hit ? v_idx : w_win_idx;
      w_grant   = w_grant | v_hit;
    end
    w_req_ready = w_grant ? (ONE_HOT0 << w_win_idx) : {NUM_REQ{1'b0}};
  end

  // Operand select for the winner; the grant path never looks at data.
  always_comb begin
    w_win_data = {OPW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_data = (w_win_idx == ID_W'(i)) ? req_data[i*OPW +: OPW] : w_win_data;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_grant ? ST_CALC : ST_IDLE;
      ST_CALC: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = w_grant ? ST_CALC : ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand, tag and round-robin pointer load on a grant, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand <= {OPW{1'b0}};
      r_out_id  <= {ID_W{1'b0}};
      r_rr      <= ID_W'(NUM_REQ-1);
    end else if (w_grant) begin
      r_operand <= w_win_data;
      r_out_id  <= w_win_idx;
      r_rr      <= w_win_idx;
    end else begin
      r_operand <= r_operand;
      r_out_id  <= r_out_id;
      r_rr      <= r_rr;
    end
  end

  relu #(
    .dataWidth      (dataWidth),
    .weightIntWidth (weightIntWidth)
  ) u_relu (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (r_operand),
    .out   (out_data)
  );

  assign req_ready = w_req_ready;
  assign out_valid = (r_state == ST_OUT);
  assign out_id    = r_out_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_relu_share_sched.sv
// Randomized scoreboard bench for relu_share_sched with a behavioural reference model.

module tb_relu_share_sched;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int WIW     = 4;
  localparam int ID_W    = 2;
  localparam int OPW     = 2 * DW;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*OPW-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [DW-1:0]            out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready = 1'b0;
  logic                     busy;

  typedef struct {
    logic [DW-1:0] data;
    int            id;
    int            ta;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_grant = NUM_REQ - 1;

  relu_share_sched #(
    .NUM_REQ(NUM_REQ), .dataWidth(DW), .weightIntWidth(WIW), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] relu_ref(input logic [OPW-1:0] x);
    logic signed [OPW-1:0] sx;
    sx = x;
    if (sx < 0) return '0;
    if (x >= (32'd1 << (OPW - 1 - WIW))) return {1'b0, {(DW-1){1'b1}}};
    return DW'(x >> (DW - WIW));
  endfunction

  function automatic logic [NUM_REQ*OPW-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c, input logic [31:0] e);
    return {e, c, b, a};
  endfunction

  function automatic logic [31:0] rand_sum();
    case ($urandom_range(0, 3))
      0: return $urandom & 32'h07FF_FFFF;
      1: return $urandom | 32'h8000_0000;
      2: return 32'h0800_0000 | ($urandom & 32'h77FF_FFFF);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs, then checks grant and busy against the model.
  task automatic drive_and_check(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*OPW-1:0] d,
                                 input logic ordy);
    bit can;
    int win;
    logic [NUM_REQ-1:0] exp_rdy;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    #2;
    can = (q.size() == 0) || ((cyc >= q[0].ta + 2) && ordy);
    win = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last_grant + k) % NUM_REQ;
      if (can && win < 0 && v[idx]) win = idx;
    end
    exp_rdy = (win >= 0) ? NUM_REQ'(1 << win) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (win >= 0) begin
      exp_t e;
      e.data = relu_ref(d[win*OPW +: OPW]);
      e.id   = win;
      e.ta   = cyc;
      q.push_back(e);
      last_grant = win;
    end
  endtask

  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*OPW-1:0] d,
                      input logic ordy);
    @(posedge clk);
    cyc++;
    #1;
    drive_and_check(v, d, ordy);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    forever @(negedge clk) begin
      bit ev;
      ev = (q.size() > 0) && (cyc >= q[0].ta + 2);
      if (rst_n) begin
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev && out_valid) begin
          chk("out_data", 32'(out_data), 32'(q[0].data));
          chk("out_id", 32'(out_id), 32'(q[0].id));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] sat_vals [3];
    logic [NUM_REQ*OPW-1:0] d;
    sat_vals[0] = 32'h0800_0000;
    sat_vals[1] = 32'hFFFF_0000;
    sat_vals[2] = 32'h07FF_F000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // Single request
    step(4'b0001, mk(32'h0001_2345, 32'd0, 32'd0, 32'd0), 1'b1);
    repeat (3) step(4'b0000, '0, 1'b1);

    // Saturation, negative and slice-boundary sums
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, mk(sat_vals[i], 32'd0, 32'd0, 32'd0), 1'b1);
      repeat (2) step(4'b0000, '0, 1'b1);
    end

    // Fairness with everyone requesting
    d = mk(32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 32'h0040_0000);
    repeat (10) step(4'b1111, d, 1'b1);
    repeat (3) step(4'b0000, '0, 1'b1);

    // Backpressure with requester 2 pending
    d = mk(32'h0123_4000, 32'd0, 32'h0567_8000, 32'd0);
    step(4'b0001, d, 1'b0);
    repeat (6) step(4'b0100, d, 1'b0);
    step(4'b0100, d, 1'b1);
    repeat (3) step(4'b0000, '0, 1'b1);

    // Skip and wrap
    d = mk(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000);
    step(4'b1000, d, 1'b1);
    repeat (2) step(4'b0000, '0, 1'b1);
    step(4'b0100, d, 1'b1);
    repeat (2) step(4'b0000, '0, 1'b1);
    step(4'b0011, d, 1'b1);
    repeat (3) step(4'b0000, '0, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      d = mk(rand_sum(), rand_sum(), rand_sum(), rand_sum());
      step(4'($urandom_range(0, 15)), d, ($urandom_range(0, 3) != 0));
    end
    repeat (6) step(4'b0000, '0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);

    // Reset while in CALC
    step(4'b0001, mk(32'h0004_0000, 32'd0, 32'd0, 32'd0), 1'b1);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    q.delete();
    last_grant = NUM_REQ - 1;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    drive_and_check(4'b0010, mk(32'd0, 32'h0040_0000, 32'd0, 32'd0), 1'b1);
    repeat (4) step(4'b0000, '0, 1'b1);
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
